// File: rtl/heap_initiator_if.sv
// heap_initiator_if: request/response handshake and Memory heap port bundle.
// The master side is the initiator; the slave side is the sequencer plus Memory.
interface heap_initiator_if #(
   parameter int ADDRESS_BITS = 2,
   parameter int INDEX_BITS   = 1,
   parameter int DATA_BITS    = 12
);
   logic                    req_valid;
   logic                    req_ready;
   logic [7:0]              req_action;
   logic [ADDRESS_BITS-1:0] req_array;
   logic [INDEX_BITS-1:0]   req_index;
   logic [DATA_BITS-1:0]    req_in;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_BITS-1:0]    rsp_out;
   logic [31:0]             rsp_error;
   logic                    heapClock;
   logic [7:0]              heapAction;
   logic [ADDRESS_BITS-1:0] heapArray;
   logic [INDEX_BITS-1:0]   heapIndex;
   logic [DATA_BITS-1:0]    heapIn;
   logic [DATA_BITS-1:0]    heapOut;
   logic [31:0]             heapError;

   modport master (
      input  req_valid, req_action, req_array, req_index, req_in,
      input  rsp_ready, heapOut, heapError,
      output req_ready, rsp_valid, rsp_out, rsp_error,
      output heapClock, heapAction, heapArray, heapIndex, heapIn
   );

   modport slave (
      output req_valid, req_action, req_array, req_index, req_in,
      output rsp_ready, heapOut, heapError,
      input  req_ready, rsp_valid, rsp_out, rsp_error,
      input  heapClock, heapAction, heapArray, heapIndex, heapIn
   );
endinterface

// File: rtl/heap_initiator.sv
// heap_initiator: turns one valid/ready request into exactly one heapClock
// transition, waits a fixed settle time, captures the Memory result and holds
// it on the response channel until the consumer takes it.
module heap_initiator #(
   parameter int ADDRESS_BITS  = 2,
   parameter int INDEX_BITS    = 1,
   parameter int DATA_BITS     = 12,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset,
   heap_initiator_if.master bus,
   output logic [15:0]      completed
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] STROBE  = 2'd1;
   localparam logic [1:0] SETTLE  = 2'd2;
   localparam logic [1:0] RESPOND = 2'd3;

   localparam logic [3:0]  SETTLE_LOAD          = 4'(SETTLE_CYCLES);
   localparam logic [31:0] ILLEGAL_ACTION_ERROR = 32'h1000_0280;

   logic [1:0]              state;
   logic [3:0]              settleCount;
   logic                    heapClockReg;
   logic [7:0]              actionReg;
   logic [ADDRESS_BITS-1:0] arrayReg;
   logic [INDEX_BITS-1:0]   indexReg;
   logic [DATA_BITS-1:0]    inReg;
   logic                    rspValidReg;
   logic [DATA_BITS-1:0]    rspOutReg;
   logic [31:0]             rspErrorReg;
   logic [15:0]             completedCount;
   logic                    actionLegal;
   logic                    rspHandshake;

   // Actions 1..30 exist at Memory; anything else is answered locally.
   assign actionLegal  = (bus.req_action >= 8'd1) && (bus.req_action <= 8'd30);
   assign rspHandshake = (state == RESPOND) && bus.rsp_ready;

   // Ready is held low while reset is asserted so nothing is accepted then.
   assign bus.req_ready  = (state == IDLE) && reset;
   assign bus.rsp_valid  = rspValidReg;
   assign bus.rsp_out    = rspOutReg;
   assign bus.rsp_error  = rspErrorReg;
   assign bus.heapClock  = heapClockReg;
   assign bus.heapAction = actionReg;
   assign bus.heapArray  = arrayReg;
   assign bus.heapIndex  = indexReg;
   assign bus.heapIn     = inReg;
   assign completed      = completedCount;

   // Request sequencer: accept, strobe heapClock once, settle, then hold the result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         settleCount  <= '0;
         heapClockReg <= 1'b0;
         actionReg    <= '0;
         arrayReg     <= '0;
         indexReg     <= '0;
         inReg        <= '0;
         rspValidReg  <= 1'b0;
         rspOutReg    <= '0;
         rspErrorReg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (actionLegal) begin
                     actionReg <= bus.req_action;
                     arrayReg  <= bus.req_array;
                     indexReg  <= bus.req_index;
                     inReg     <= bus.req_in;
                     state     <= STROBE;
                  end else begin
                     rspOutReg   <= '0;
                     rspErrorReg <= ILLEGAL_ACTION_ERROR;
                     rspValidReg <= 1'b1;
                     state       <= RESPOND;
                  end
               end
            end
            STROBE: begin
               heapClockReg <= ~heapClockReg;
               settleCount  <= SETTLE_LOAD;
               state        <= SETTLE;
            end
            SETTLE: begin
               settleCount <= settleCount - 4'd1;
               if (settleCount == 4'd1) begin
                  rspOutReg   <= bus.heapOut;
                  rspErrorReg <= bus.heapError;
                  rspValidReg <= 1'b1;
                  state       <= RESPOND;
               end
            end
            RESPOND: begin
               if (bus.rsp_ready) begin
                  rspValidReg <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Count of consumed responses, wrapping naturally at 16 bits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         completedCount <= '0;
      end else if (rspHandshake) begin
         completedCount <= completedCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_heap_initiator.sv
// tb_heap_initiator: drives heap_initiator with directed and random requests
// against a behavioural Memory and a transaction-level reference model.
module tb_heap_initiator;
   localparam int ADDRESS_BITS  = 2;
   localparam int INDEX_BITS    = 1;
   localparam int DATA_BITS     = 12;
   localparam int SETTLE_CYCLES = 2;
   localparam logic [31:0] ILLEGAL_CODE = 32'h1000_0280;

   logic        clock;
   logic        reset;
   logic [15:0] completed;

   heap_initiator_if #(
      .ADDRESS_BITS(ADDRESS_BITS),
      .INDEX_BITS  (INDEX_BITS),
      .DATA_BITS   (DATA_BITS)
   ) bus ();

   heap_initiator #(
      .ADDRESS_BITS (ADDRESS_BITS),
      .INDEX_BITS   (INDEX_BITS),
      .DATA_BITS    (DATA_BITS),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .completed(completed)
   );

   int checkCount = 0;
   int errorCount = 0;

   // Behavioural Memory contents
   int          arraySizes [4];
   logic [11:0] elements   [4][2];

   // Reference model state: what the heap port and counters should show
   logic        modelParity;
   logic [7:0]  modelAction;
   logic [1:0]  modelArray;
   logic        modelIndex;
   logic [11:0] modelIn;
   logic [15:0] modelCompleted;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory result for an action; Size and Greater follow Memory semantics.
   function automatic logic [11:0] memData(input logic [7:0] a, input logic [1:0] arr,
                                           input logic idx, input logic [11:0] din);
      int count;
      int size;
      if (a == 8'd4) return 12'(arraySizes[arr]);
      if (a == 8'd9) begin
         count = 0;
         size  = (arraySizes[arr] > 2) ? 2 : arraySizes[arr];
         for (int i = 0; i < size; i++)
            if (elements[arr][i] > din) count++;
         return 12'(count);
      end
      return 12'((int'(a) * 37 + int'(arr) * 11 + int'(idx) * 5) ^ int'(din));
   endfunction

   function automatic logic [31:0] memError(input logic [7:0] a, input logic [11:0] din);
      if (a == 8'd13) return 32'h2000_0000 | {24'h0, din[7:0]};
      return 32'h0;
   endfunction

   // Memory reacts to every heapClock transition except the no-op action.
   always @(bus.heapClock) begin
      if (reset === 1'b1 && bus.heapAction != 8'd0) begin
         bus.heapOut   = memData(bus.heapAction, bus.heapArray, bus.heapIndex, bus.heapIn);
         bus.heapError = memError(bus.heapAction, bus.heapIn);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One full request/response transaction checked against the reference model.
   task automatic applyStimulus(input logic [7:0] action, input logic [1:0] array,
                                input logic index, input logic [11:0] din,
                                input int holdCycles, input bit holdReady,
                                input bit scramble);
      logic        legal;
      logic [11:0] expOut;
      logic [31:0] expErr;
      int          expLatency;
      int          cycles;
      int          waitCount;
      legal = (action >= 8'd1) && (action <= 8'd30);
      if (legal) begin
         expOut     = memData(action, array, index, din);
         expErr     = memError(action, din);
         expLatency = 2 + SETTLE_CYCLES;
      end else begin
         expOut     = 12'h000;
         expErr     = ILLEGAL_CODE;
         expLatency = 1;
      end
      @(negedge clock);
      waitCount = 0;
      while (bus.req_ready !== 1'b1 && waitCount < 20) begin
         @(negedge clock);
         waitCount++;
      end
      checkOutput("req_ready_before_request", 32'(bus.req_ready), 32'd1);
      bus.rsp_ready  = holdReady;
      bus.req_action = action;
      bus.req_array  = array;
      bus.req_index  = index;
      bus.req_in     = din;
      bus.req_valid  = 1'b1;
      @(posedge clock);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_action = 8'($urandom);
      bus.req_array  = 2'($urandom);
      bus.req_index  = 1'($urandom);
      bus.req_in     = 12'($urandom);
      if (legal) begin
         modelAction = action;
         modelArray  = array;
         modelIndex  = index;
         modelIn     = din;
      end
      checkOutput("heap_bus_after_accept",
                  32'({bus.heapAction, bus.heapArray, bus.heapIndex, bus.heapIn}),
                  32'({modelAction, modelArray, modelIndex, modelIn}));
      checkOutput("heapClock_after_accept", 32'(bus.heapClock), 32'(modelParity));
      if (legal) modelParity = ~modelParity;
      cycles = 1;
      while (bus.rsp_valid !== 1'b1 && cycles < 40) begin
         @(posedge clock);
         #1;
         cycles++;
      end
      checkOutput("response_latency", 32'(cycles), 32'(expLatency));
      checkOutput("rsp_out", 32'(bus.rsp_out), 32'(expOut));
      checkOutput("rsp_error", bus.rsp_error, expErr);
      checkOutput("heapClock_parity", 32'(bus.heapClock), 32'(modelParity));
      checkOutput("req_ready_while_busy", 32'(bus.req_ready), 32'd0);
      if (!holdReady) begin
         for (int i = 0; i < holdCycles; i++) begin
            @(negedge clock);
            if (scramble) begin
               bus.heapOut   = 12'($urandom);
               bus.heapError = $urandom;
            end
            @(posedge clock);
            #1;
            checkOutput("held_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("held_rsp_out", 32'(bus.rsp_out), 32'(expOut));
            checkOutput("held_rsp_error", bus.rsp_error, expErr);
            checkOutput("held_req_ready", 32'(bus.req_ready), 32'd0);
         end
      end
      @(negedge clock);
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      modelCompleted = modelCompleted + 16'd1;
      checkOutput("rsp_valid_after_handshake", 32'(bus.rsp_valid), 32'd0);
      checkOutput("completed", 32'(completed), 32'(modelCompleted));
      checkOutput("req_ready_after_handshake", 32'(bus.req_ready), 32'd1);
      if (!holdReady) bus.rsp_ready = 1'b0;
   endtask

   task automatic resetModel();
      modelParity    = 1'b0;
      modelAction    = 8'h00;
      modelArray     = 2'b00;
      modelIndex     = 1'b0;
      modelIn        = 12'h000;
      modelCompleted = 16'h0000;
   endtask

   // Abandon a Size request mid-settle with an asynchronous reset.
   task automatic applyMidReset();
      int sawValid;
      @(negedge clock);
      bus.req_action = 8'd4;
      bus.req_array  = 2'd1;
      bus.req_index  = 1'b0;
      bus.req_in     = 12'h000;
      bus.req_valid  = 1'b1;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      resetModel();
      checkOutput("midreset_heapClock", 32'(bus.heapClock), 32'd0);
      checkOutput("midreset_heap_bus",
                  32'({bus.heapAction, bus.heapArray, bus.heapIndex, bus.heapIn}), 32'd0);
      checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("midreset_rsp_out", 32'(bus.rsp_out), 32'd0);
      checkOutput("midreset_rsp_error", bus.rsp_error, 32'd0);
      checkOutput("midreset_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("midreset_completed", 32'(completed), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("req_ready_after_release", 32'(bus.req_ready), 32'd1);
      sawValid = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.rsp_valid !== 1'b0) sawValid++;
         @(posedge clock);
         #1;
      end
      checkOutput("no_rsp_after_reset", 32'(sawValid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] act;
      arraySizes[0] = 0;
      arraySizes[1] = 1;
      arraySizes[2] = 2;
      arraySizes[3] = 1;
      elements[0][0] = 12'h000; elements[0][1] = 12'h000;
      elements[1][0] = 12'h00A; elements[1][1] = 12'h000;
      elements[2][0] = 12'd7;   elements[2][1] = 12'd3;
      elements[3][0] = 12'h123; elements[3][1] = 12'h000;
      resetModel();
      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_action = 8'h00;
      bus.req_array  = 2'b00;
      bus.req_index  = 1'b0;
      bus.req_in     = 12'h000;
      bus.rsp_ready  = 1'b0;
      bus.heapOut    = 12'h000;
      bus.heapError  = 32'h0;

      #12;
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("reset_heapClock", 32'(bus.heapClock), 32'd0);
      checkOutput("reset_heap_bus",
                  32'({bus.heapAction, bus.heapArray, bus.heapIndex, bus.heapIn}), 32'd0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_completed", 32'(completed), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("req_ready_after_reset", 32'(bus.req_ready), 32'd1);

      $display("[TB] directed requests");
      applyStimulus(8'd4, 2'd1, 1'b0, 12'h000, 0, 1'b0, 1'b0);
      applyStimulus(8'd9, 2'd2, 1'b0, 12'd5, 0, 1'b0, 1'b0);
      applyStimulus(8'd31, 2'd3, 1'b1, 12'hABC, 0, 1'b0, 1'b0);
      applyStimulus(8'd0, 2'd1, 1'b1, 12'h111, 0, 1'b0, 1'b0);
      applyStimulus(8'd17, 2'd3, 1'b1, 12'h3C5, 10, 1'b0, 1'b1);
      applyStimulus(8'd13, 2'd0, 1'b0, 12'h05A, 1, 1'b0, 1'b0);
      applyStimulus(8'd30, 2'd1, 1'b0, 12'h0F0, 0, 1'b1, 1'b0);
      applyStimulus(8'd1, 2'd2, 1'b1, 12'h001, 0, 1'b1, 1'b0);
      applyStimulus(8'd200, 2'd2, 1'b1, 12'h001, 0, 1'b1, 1'b0);
      bus.rsp_ready = 1'b0;

      $display("[TB] random requests");
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0)
            act = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(31, 255));
         else
            act = 8'($urandom_range(1, 30));
         applyStimulus(act, 2'($urandom), 1'($urandom), 12'($urandom),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end
      bus.rsp_ready = 1'b0;

      $display("[TB] completed wrap");
      @(negedge clock);
      force dut.completedCount = 16'hFFFF;
      #1;
      release dut.completedCount;
      modelCompleted = 16'hFFFF;
      #1;
      checkOutput("completed_preload", 32'(completed), 32'h0000FFFF);
      applyStimulus(8'd4, 2'd2, 1'b0, 12'h000, 0, 1'b0, 1'b0);

      $display("[TB] reset during settle");
      applyMidReset();
      applyStimulus(8'd4, 2'd1, 1'b0, 12'h000, 0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
